// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared core constants (NOP encoding, default width, issue-mask bit positions)
package instr_fetch_queue_pkg;
    localparam int IFQ_IW = 32;
    localparam logic [IFQ_IW-1:0] NOP = 32'h0000_0000;
    localparam int SLOT1_BIT = 0;
    localparam int SLOT2_BIT = 1;
endpackage

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: ordered compacting instruction buffer feeding a two-wide dispatch
// Ports: clk/reset (sync, active-high); push_valid/push_instr/push_ready fetch handshake;
// flush discards all entries; instr1/instr2 show entries 0/1 (NOP when absent);
// shift_count is the dispatch consume mask; count/empty/full report occupancy.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IW    = IFQ_IW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid,
    input  logic [IW-1:0]                push_instr,
    output logic                         push_ready,
    input  logic                         flush,
    output logic [IW-1:0]                instr1,
    output logic [IW-1:0]                instr2,
    input  logic [1:0]                   shift_count,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int CW = $clog2(DEPTH+1);

    logic [IW-1:0] entries_q [DEPTH];
    logic [IW-1:0] entries_d [DEPTH];
    logic [IW-1:0] up1 [DEPTH];
    logic [IW-1:0] up2 [DEPTH];
    logic [CW-1:0] count_q, count_d, wr_idx;
    logic [1:0]    popped;
    logic          pop0, pop1, push_fire;

    // Neighbours one and two slots up; beyond the top they are don't-care.
    for (genvar i = 0; i < DEPTH; i++) begin : g_up
        if (i + 1 < DEPTH) begin : g_u1
            assign up1[i] = entries_q[i+1];
        end else begin : g_z1
            assign up1[i] = '0;
        end
        if (i + 2 < DEPTH) begin : g_u2
            assign up2[i] = entries_q[i+2];
        end else begin : g_z2
            assign up2[i] = '0;
        end
    end

    // Mask bits for absent slots are ignored.
    assign pop0      = shift_count[SLOT1_BIT] && (count_q != '0);
    assign pop1      = shift_count[SLOT2_BIT] && (count_q > CW'(1));
    assign popped    = {1'b0, pop0} + {1'b0, pop1};
    assign push_fire = push_valid && push_ready;
    assign wr_idx    = count_q - CW'(popped);

    always_comb begin
        count_d = flush ? '0 : wr_idx + CW'(push_fire);
        for (int j = 0; j < DEPTH; j++) begin
            // Mask 10 keeps entry 0 and closes the gap at entry 1 only.
            entries_d[j] = (pop0 && pop1) ? up2[j] :
                           pop0 ? up1[j] :
                           (pop1 && j != 0) ? up1[j] : entries_q[j];
            if (push_fire && CW'(j) == wr_idx) entries_d[j] = push_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign count      = count_q;
    assign empty      = count_q == '0;
    assign full       = count_q == CW'(DEPTH);
    assign push_ready = !full;
    assign instr1     = (count_q != '0)     ? entries_q[0] : IW'(NOP);
    assign instr2     = (count_q > CW'(1))  ? entries_q[1] : IW'(NOP);
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: scoreboard bench for instr_fetch_queue with directed vectors
module tb_instr_fetch_queue;
    logic        clk = 0;
    logic        reset = 1;
    logic        push_valid = 0;
    logic [31:0] push_instr = '0;
    logic        push_ready;
    logic        flush = 0;
    logic [31:0] instr1, instr2;
    logic [1:0]  shift_count = '0;
    logic [3:0]  count;
    logic        empty, full;

    instr_fetch_queue #(.DEPTH(8), .IW(32)) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_instr(push_instr),
        .push_ready(push_ready), .flush(flush), .instr1(instr1), .instr2(instr2),
        .shift_count(shift_count), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   edges = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic void chk(string n, string f, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", n, f, got, want);
        end
    endfunction

    // Monitor: compares the DUT outputs against the oldest expectation due this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= edges) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < edges) begin
                total++;
                bad++;
                $display("FAIL %s.missed got=%0d want=%0d", e.name, edges, e.cyc);
            end else begin
                chk(e.name, "instr1", instr1, e.i1);
                chk(e.name, "instr2", instr2, e.i2);
                chk(e.name, "count", {28'h0, count}, {28'h0, e.cnt});
                chk(e.name, "empty", {31'h0, empty}, {31'h0, e.cnt == 4'd0});
                chk(e.name, "full", {31'h0, full}, {31'h0, e.cnt == 4'd8});
                chk(e.name, "push_ready", {31'h0, push_ready}, {31'h0, e.cnt != 4'd8});
            end
        end
    end

    task automatic step(input bit rst, input bit pv, input logic [31:0] pi,
                        input logic [1:0] sc, input bit fl);
        reset = rst; push_valid = pv; push_instr = pi; shift_count = sc; flush = fl;
        @(posedge clk);
        #1;
        reset = 0; push_valid = 0; shift_count = '0; flush = 0;
    endtask

    task automatic expect_now(input string n, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] c);
        exp_t e;
        e.cyc = edges; e.name = n; e.i1 = a; e.i2 = b; e.cnt = c;
        sb.push_back(e);
    endtask

    localparam logic [31:0] A = 32'hA000_000A, B = 32'hB000_000B, C = 32'hC000_000C;
    localparam logic [31:0] D = 32'hD000_000D, E = 32'hE000_000E, F = 32'hF000_000F;
    localparam logic [31:0] G = 32'h6000_0006, X = 32'h7777_7777, Y = 32'h8888_8888;
    localparam logic [31:0] Z = 32'h5A5A_5A5A;

    initial begin
        step(1, 0, '0, 2'b00, 0);
        step(1, 1, X, 2'b11, 1);
        expect_now("reset_push_dropped", 32'h0, 32'h0, 4'd0);
        step(0, 1, A, 2'b00, 0);
        expect_now("push_a", A, 32'h0, 4'd1);
        step(0, 1, B, 2'b00, 0);
        expect_now("push_b", A, B, 4'd2);
        step(0, 1, C, 2'b00, 0);
        expect_now("push_abc", A, B, 4'd3);
        step(0, 1, D, 2'b00, 0);
        expect_now("push_d", A, B, 4'd4);
        step(0, 0, '0, 2'b10, 0);
        expect_now("pop_slot2_only", A, C, 4'd3);
        step(0, 0, '0, 2'b01, 0);
        expect_now("pop_slot1", C, D, 4'd2);
        step(0, 0, '0, 2'b00, 1);
        expect_now("flush_plain", 32'h0, 32'h0, 4'd0);
        step(0, 1, A, 2'b00, 0);
        step(0, 1, B, 2'b00, 0);
        step(0, 1, C, 2'b00, 0);
        expect_now("refill_abc", A, B, 4'd3);
        step(0, 1, E, 2'b11, 0);
        expect_now("pop2_push_e", C, E, 4'd2);
        step(0, 1, F, 2'b01, 0);
        expect_now("pop1_push_f", E, F, 4'd2);
        step(0, 0, '0, 2'b10, 0);
        expect_now("pop_slot2_last", E, 32'h0, 4'd1);
        step(0, 0, '0, 2'b11, 0);
        expect_now("pop11_single", 32'h0, 32'h0, 4'd0);
        step(0, 0, '0, 2'b11, 0);
        expect_now("pop_empty_no_underflow", 32'h0, 32'h0, 4'd0);
        for (int k = 0; k < 8; k++) step(0, 1, 32'h1000_0000 + k, 2'b00, 0);
        expect_now("fill_full", 32'h1000_0000, 32'h1000_0001, 4'd8);
        step(0, 1, X, 2'b00, 0);
        expect_now("push_when_full", 32'h1000_0000, 32'h1000_0001, 4'd8);
        step(0, 1, Y, 2'b01, 0);
        expect_now("full_pop_no_push", 32'h1000_0001, 32'h1000_0002, 4'd7);
        step(0, 0, '0, 2'b11, 0);
        expect_now("drain_5", 32'h1000_0003, 32'h1000_0004, 4'd5);
        step(0, 0, '0, 2'b11, 0);
        expect_now("drain_3", 32'h1000_0005, 32'h1000_0006, 4'd3);
        step(0, 0, '0, 2'b11, 0);
        expect_now("drain_1_y_absent", 32'h1000_0007, 32'h0, 4'd1);
        step(0, 1, Z, 2'b01, 0);
        expect_now("pop_push_at_zero", Z, 32'h0, 4'd1);
        for (int k = 0; k < 4; k++) step(0, 1, 32'h2000_0000 + k, 2'b00, 0);
        expect_now("five_entries", Z, 32'h2000_0000, 4'd5);
        step(0, 1, X, 2'b01, 1);
        expect_now("flush_beats_push", 32'h0, 32'h0, 4'd0);
        step(0, 1, G, 2'b00, 0);
        expect_now("after_flush_push", G, 32'h0, 4'd1);
        step(0, 1, D, 2'b00, 0);
        expect_now("two_after_flush", G, D, 4'd2);
        step(1, 1, X, 2'b01, 0);
        expect_now("reset_priority", 32'h0, 32'h0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s.unchecked got=pending want=checked", e.name);
        end
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout got=%0d want=finished", edges);
            $fatal(1, "timeout");
        end
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, 8, number of instruction entries; legal values are 4 to 16.
REQ-002 Parameter IW, 32, instruction width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 push_valid  input  1  fetch side offers one instruction this cycle.
REQ-006 push_instr  input  IW  instruction offered by the fetch side.
REQ-007 push_ready  output  1  queue accepts push_instr this cycle.
REQ-008 flush  input  1  synchronous discard of all entries.
REQ-009 instr1  output  IW  entry 0 (oldest), or NOP when absent.
REQ-010 instr2  output  IW  entry 1, or NOP when absent.
REQ-011 shift_count  input  2  issue mask from dispatch: bit0 = instr1 consumed, bit1 = instr2 consumed.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-013 empty, full  output  1 each  count==0; count==DEPTH.

Function
REQ-014 The queue SHALL be an ordered, compacting buffer: entry 0 is always the oldest valid instruction, and valid entries SHALL occupy indices 0..count-1 with no gaps.
REQ-015 instr1 and instr2 SHALL be driven combinationally from entries 0 and 1; any slot with index >= count SHALL drive NOP = 32'h0000_0000, which dispatch decodes as not consumable.
REQ-016 push_ready SHALL equal !full; a push completes when push_valid && push_ready.
REQ-017 A pushed instruction SHALL appear on instr1/instr2 on the cycle after acceptance, never in the same cycle.
REQ-018 Effective pop mask SHALL be shift_count AND {count>=2, count>=1}; bits set for absent slots SHALL be ignored.
REQ-019 Mask 2'b01: remove entry 0; all remaining entries shift down by 1.
REQ-020 Mask 2'b11: remove entries 0 and 1; remaining entries shift down by 2.
REQ-021 Mask 2'b10 (out-of-order issue of slot 2): remove entry 1 only; entry 0 is retained; entries 2.. shift down by 1.
REQ-022 Mask 2'b00: no removal.
REQ-023 Pop and push in the same cycle SHALL both take effect; the new entry SHALL be written at index count - popped, and count_next = count - popped + pushed.
REQ-024 When full, a same-cycle pop SHALL NOT enable a push; push_ready depends only on the registered count.
REQ-025 flush SHALL set count to 0 on the next edge; flush takes priority over the same-cycle push and pop, and the pushed instruction is discarded.
REQ-026 Entry contents at indices >= count are don't-care internally, but SHALL never reach the outputs (REQ-015).
REQ-027 count SHALL never exceed DEPTH and never underflow, under any input combination.

Reset
REQ-028 While reset is high at a clock edge: count=0, so empty=1, full=0, push_ready=1, and instr1=instr2=NOP.
REQ-029 Reset SHALL take priority over flush, push and pop; a push asserted during reset is dropped.
REQ-030 Entry storage need not be cleared by reset.

Structure
REQ-031 The NOP constant, the default IW, and the shift_count bit positions (SLOT1_BIT=0, SLOT2_BIT=1) SHALL live in the shared core package, and dispatch_and_decode_unit SHALL use the same package constants.
REQ-032 The block SHALL be one module with no sub-module; the compaction mux per entry index is computed inline from the pop mask.

Verification
REQ-033 Reset, then push A,B,C on three consecutive cycles with shift_count=0 -> cycle after the third push: instr1=A, instr2=B, count=3.
REQ-034 Queue holding A,B,C,D; apply shift_count=2'b10 for one cycle -> next cycle: instr1=A, instr2=C, count=3.
REQ-035 Queue holding A,B,C; apply shift_count=2'b11 and push E in the same cycle -> next cycle: instr1=C, instr2=E, count=2.
REQ-036 Fill to 8 entries (full=1, push_ready=0); hold push_valid with shift_count=2'b01 -> next cycle: count=7, the pushed instruction is not accepted, push_ready=1.
REQ-037 Queue holding only A; apply shift_count=2'b11 -> next cycle: count=0, instr1=instr2=32'h0, no underflow.
REQ-038 Queue holding 5 entries; assert flush together with push X -> next cycle: count=0, empty=1, and X is absent from both output slots.
